regread_1: RTL

//  Transmit end of the one-hot bit-write interface: drives (ctrl, out) pairs that a bit-addressed

---
 rtl/regread_1.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regread_1.sv
// Transmit side of the one-hot bit-write link: snapshots a word on start and walks a
// one-hot select across it, presenting each bit's value for HOLD cycles per slot.
module regread_1 #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] ctrl,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int IW = $clog2(WIDTH);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [IW-1:0] IdxLast  = IW'(WIDTH - 1);
  localparam logic [HW-1:0] HoldLast = HW'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] ctrl_q, ctrl_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IW-1:0]    nextIdx;

  assign nextIdx = idx_q + IW'(1);

  // Terminal counts are compared explicitly so the index never runs past the last bit.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ctrl_d   = ctrl_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    out_d    = out_q;
    busy_d   = busy_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE: begin
        ctrl_d = '0;
        out_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        idx_d  = '0;
        hold_d = '0;
        if (start) begin
          shadow_d = din;
          ctrl_d   = {{(WIDTH-1){1'b0}}, 1'b1};
          out_d    = din[0];
          busy_d   = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          ctrl_d  = '0;
          out_d   = 1'b0;
          busy_d  = 1'b0;
          idx_d   = '0;
          hold_d  = '0;
          state_d = IDLE;
        end else if (hold_q == HoldLast) begin
          hold_d = '0;
          if (idx_q == IdxLast) begin
            ctrl_d  = '0;
            out_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d  = nextIdx;
            ctrl_d = {ctrl_q[WIDTH-2:0], 1'b0};
            out_d  = shadow_q[nextIdx];
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        ctrl_d  = '0;
        out_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        idx_d   = '0;
        hold_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      ctrl_q   <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ctrl_q   <= ctrl_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ctrl = ctrl_q;
  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
